// File: rtl/pipe_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_shifter
// Description : Pipelined barrel shifter (SLL/SRA/ROR/SRL), one register stage
//               per shift-amount bit, valid/ready with global stall.
//               Rotate hardware is built only when PIPE_SHIFTER_ROR_EN is defined.
// Revision    : 1.0
// ============================================================================
module pipe_shifter #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic                     out_neg
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int L       = SHAMT_W;
    localparam int REM_W   = (L * (L - 1)) / 2;

    // Stage s keeps only the shamt bits still needed downstream; slices are packed back to back.
    function automatic int rem_off(input int s);
        return s * (L - 1) - (s * (s - 1)) / 2;
    endfunction

    logic             adv;
    logic [L-1:0]     valid_q;
    logic [WIDTH-1:0] data_q [L];
    logic [TAG_W-1:0] tag_q  [L];
    logic [1:0]       mode_q [L-1];
    logic [L-2:0]     sign_q;
    logic [REM_W-1:0] rem_q;
    logic             zero_q;
    logic             neg_q;

    assign adv      = !valid_q[L-1] || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int SH = 1 << s;

        logic [WIDTH-1:0] w_src;
        logic [TAG_W-1:0] w_tag;
        logic [1:0]       w_mode;
        logic             w_sign;
        logic             w_valid;
        logic             w_bit;
        logic [WIDTH-1:0] w_srl;
        logic [WIDTH-1:0] data_d;

        if (s == 0) begin : g_head
            assign w_src   = in_data;
            assign w_tag   = in_tag;
            assign w_mode  = in_mode;
            assign w_sign  = in_data[WIDTH-1];
            assign w_valid = in_valid;
            assign w_bit   = in_shamt[0];
        end else begin : g_body
            localparam int OFF_P = rem_off(s - 1);
            assign w_src   = data_q[s-1];
            assign w_tag   = tag_q[s-1];
            assign w_mode  = mode_q[s-1];
            assign w_sign  = sign_q[s-1];
            assign w_valid = valid_q[s-1];
            assign w_bit   = rem_q[OFF_P];
        end

        always_comb begin
            w_srl  = w_src >> SH;
            data_d = w_src;
            if (w_bit) begin
                case (w_mode)
                    2'b01:   data_d = w_srl | ({WIDTH{w_sign}} & ~({WIDTH{1'b1}} >> SH));
`ifdef PIPE_SHIFTER_ROR_EN
                    2'b10:   data_d = w_srl | (w_src << (WIDTH - SH));
`endif
                    2'b11:   data_d = w_srl;
                    default: data_d = w_src << SH;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                tag_q[s]   <= '0;
            end else if (adv) begin
                valid_q[s] <= w_valid;
                data_q[s]  <= data_d;
                tag_q[s]   <= w_tag;
            end
        end

        if (s < L - 1) begin : g_fwd
            localparam int OFF = rem_off(s);
            logic [L-2-s:0] w_rem_nxt;

            if (s == 0) begin : g_rem_head
                assign w_rem_nxt = in_shamt[SHAMT_W-1:1];
            end else begin : g_rem_body
                assign w_rem_nxt = rem_q[rem_off(s - 1) + 1 +: L - 1 - s];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sign_q[s]              <= 1'b0;
                    mode_q[s]              <= 2'b00;
                    rem_q[OFF +: L - 1 - s] <= '0;
                end else if (adv) begin
                    sign_q[s]              <= w_sign;
                    mode_q[s]              <= w_mode;
                    rem_q[OFF +: L - 1 - s] <= w_rem_nxt;
                end
            end
        end else begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                end else if (adv) begin
                    zero_q <= (data_d == '0);
                    neg_q  <= data_d[WIDTH-1];
                end
            end
        end
    end

    assign out_valid = valid_q[L-1];
    assign out_data  = data_q[L-1];
    assign out_tag   = tag_q[L-1];
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;

endmodule
`default_nettype wire

// File: doc/pipe_shifter.md
# pipe_shifter

Parametrised, fully pipelined barrel shifter, the next-generation replacement for the single-cycle 16-bit combinational shifter in the execute stage. It performs logical-left, arithmetic-right, rotate-right and logical-right shifts on a WIDTH-bit operand across one register stage per shift-amount bit. Operands move through the pipeline under a valid/ready handshake with global stall, and an opaque tag travels with each operand for writeback. Zero and negative flags are produced for the flag register.

## Interface
- WIDTH, 16: operand width; power of two, ≥ 4; SHAMT_W = $clog2(WIDTH) is derived, not overridable
- TAG_W, 4: width of sideband tag carried alongside each operand
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operand/shift/mode/tag valid this cycle
- in_ready  output  1  pipeline can accept this cycle
- in_data  input  WIDTH  operand, two's complement
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_mode  input  2  00 SLL, 01 SRA, 10 ROR, 11 SRL
- in_tag  input  TAG_W  sideband, returned unmodified
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_tag  output  TAG_W  tag of this result
- out_zero  output  1  out_data == 0
- out_neg  output  1  out_data[WIDTH-1]

## Operation
- L = SHAMT_W stages; stage k (1..L) shifts by 2^(k-1) when shamt bit k-1 is set, otherwise passes data through; each stage registers data, remaining shamt bits, mode, tag, valid.
- SLL: zero fill from LSB. SRA: fill with sign bit of the original operand (carried per stage, not recomputed from intermediate). ROR: bits leaving LSB re-enter at MSB. SRL: zero fill from MSB.
- shamt = 0: out_data = in_data for every mode.
- Flags computed from the final-stage shift result and registered with it in stage L.
- Global enable adv = !out_valid || out_ready; in_ready = adv. When adv = 1 every stage loads from its predecessor (stage 1 loads inputs with valid = in_valid). When adv = 0 all stages hold; bubbles are not compressed.
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready. Results emerge in acceptance order, none dropped or duplicated.
- in_valid low with adv high inserts a bubble (valid 0); data fields of bubble stages are don't-care but must not raise out_valid.
- Simultaneous output accept and input accept in one cycle: pipeline advances one slot; both transfers succeed.

## Timing
- Reset: on edge with rst = 1, all stage valid bits and data/tag/flag registers cleared to 0; out_valid = 0, out_data = 0, out_tag = 0, out_zero = 0, out_neg = 0 after that edge; in_ready = 1 after that edge. rst overrides adv.
- Reset mid-operation: all in-flight operands discarded; nothing emerges afterwards.
- Latency: operand accepted at edge E appears with out_valid = 1 after edge E+L-1 (WIDTH = 16: visible after the 4th edge counting E), assuming no stall.
- Throughput: one operation per cycle while out_ready stays high.
- in_ready depends combinationally on out_valid and out_ready only; no path from in_valid to in_ready.
- Outputs are driven directly by stage-L registers and hold stable while out_valid && !out_ready.

## Configuration
- PIPE_SHIFTER_ROR_EN defined: mode 10 performs rotate-right as above.
- Not defined: rotate hardware omitted; mode 10 is executed as SLL (fill and result identical to mode 00). All other modes, latency and handshake unchanged.

## Test plan
- WIDTH = 16, macro on. SLL 16'h8001 by 4 -> out_data 16'h0010, out_zero 0, out_neg 0, out_valid after 4th edge from acceptance.
- SRA 16'h8000 by 15 -> 16'hFFFF, out_neg 1. SRL 16'h8000 by 15 -> 16'h0001. ROR 16'h1234 by 4 -> 16'h4123. SLL 16'h0001 by 0 -> 16'h0001.
- Macro off: mode 10, 16'h1234 by 4 -> 16'h2340. SLL 16'h8000 by 1 -> 16'h0000 with out_zero 1.
- Backpressure: offer 6 back-to-back ops with tags 0..5. Hold out_ready low for 3 cycles once the first result appears. Require in_ready = 0 and out_* stable during the stall, then tags 0..5 emerge in order with correct data.
- Bubbles: alternate in_valid 1/0 with out_ready 1. Require out_valid to alternate identically, offset by L cycles.
- Reset: assert rst for 1 cycle with 3 ops in flight. After that edge out_valid = 0 and all outputs 0, no stale result ever emerges, and a new op issued next cycle returns after L cycles. Repeat with WIDTH = 32 (L = 5).
